// File: rtl/stacked_register_file.sv
// CPU register file whose selector space includes two hardware LIFO stacks
// (parameter and return), with 1-cycle registered dual read ports and peek/pop semantics.

module stacked_register_file_lifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             a_rd,
  input  logic                             a_peek,
  input  logic                             b_rd,
  input  logic                             b_peek,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [WIDTH-1:0]                 a_val_c,
  output logic [WIDTH-1:0]                 b_val_c,
  output logic                             udf_c,
  output logic                             ovf_c
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             a_pop, b_pop, a_ok, b_ok, push_ok;
  logic [1:0]       pops;
  logic [CW-1:0]    tos, nos, removed, base, count_nxt;

  // A sees TOS; B sees NOS only when A pops the same stack. Pops land before the push.
  always_comb begin
    a_pop     = a_rd & ~a_peek;
    b_pop     = b_rd & ~b_peek;
    tos       = count - CW'(1);
    nos       = count - CW'(2);
    a_ok      = (count != '0);
    b_ok      = a_pop ? (count > CW'(1)) : a_ok;
    a_val_c   = '0;
    b_val_c   = '0;
    if (a_ok) a_val_c = mem[AW'(tos)];
    if (b_ok) b_val_c = mem[AW'(a_pop ? nos : tos)];
    udf_c     = (a_rd & ~a_ok) | (b_rd & ~b_ok);
    pops      = {1'b0, a_pop} + {1'b0, b_pop};
    removed   = (CW'(pops) > count) ? count : CW'(pops);
    base      = count - removed;
    ovf_c     = push & (base == CW'(DEPTH));
    push_ok   = push & ~ovf_c;
    count_nxt = base + CW'(push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

  // Entry storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[AW'(base)] <= push_data;
  end
endmodule

module stacked_register_file #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SEL_BITS     = 4,
  parameter int unsigned PSTACK_SEL   = 15,
  parameter int unsigned RSTACK_SEL   = 14,
  parameter int unsigned PSTACK_DEPTH = 16,
  parameter int unsigned RSTACK_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [SEL_BITS-1:0]                 a_sel,
  input  logic [SEL_BITS-1:0]                 b_sel,
  input  logic                                a_rd_en,
  input  logic                                b_rd_en,
  input  logic                                a_peek,
  input  logic                                b_peek,
  input  logic                                a_wr_en,
  input  logic [WIDTH-1:0]                    a_wr_data,
  output logic [WIDTH-1:0]                    a_rd_data,
  output logic [WIDTH-1:0]                    b_rd_data,
  output logic [$clog2(PSTACK_DEPTH+1)-1:0]   pstack_count,
  output logic [$clog2(RSTACK_DEPTH+1)-1:0]   rstack_count,
  output logic                                pstack_full,
  output logic                                pstack_empty,
  output logic                                rstack_full,
  output logic                                rstack_empty,
  output logic [3:0]                          err_flags,
  input  logic                                err_clr
);
  localparam int unsigned NREG = 2 ** SEL_BITS;
  localparam int unsigned PCW  = $clog2(PSTACK_DEPTH + 1);
  localparam int unsigned RCW  = $clog2(RSTACK_DEPTH + 1);

  logic [WIDTH-1:0] regs [NREG];
  logic             a_is_p, a_is_r, b_is_p, b_is_r;
  logic [WIDTH-1:0] p_a_val, p_b_val, r_a_val, r_b_val;
  logic [WIDTH-1:0] a_val_c, b_val_c;
  logic             p_udf, p_ovf, r_udf, r_ovf;

  always_comb begin
    a_is_p  = (a_sel == SEL_BITS'(PSTACK_SEL));
    a_is_r  = (a_sel == SEL_BITS'(RSTACK_SEL));
    b_is_p  = (b_sel == SEL_BITS'(PSTACK_SEL));
    b_is_r  = (b_sel == SEL_BITS'(RSTACK_SEL));
    a_val_c = a_is_p ? p_a_val : (a_is_r ? r_a_val : regs[a_sel]);
    b_val_c = b_is_p ? p_b_val : (b_is_r ? r_b_val : regs[b_sel]);
  end

  stacked_register_file_lifo #(.WIDTH(WIDTH), .DEPTH(PSTACK_DEPTH)) u_pstack (
    .clk(clk), .rst_n(rst_n),
    .a_rd(a_rd_en & a_is_p), .a_peek(a_peek),
    .b_rd(b_rd_en & b_is_p), .b_peek(b_peek),
    .push(a_wr_en & a_is_p), .push_data(a_wr_data),
    .count(pstack_count), .a_val_c(p_a_val), .b_val_c(p_b_val),
    .udf_c(p_udf), .ovf_c(p_ovf)
  );

  stacked_register_file_lifo #(.WIDTH(WIDTH), .DEPTH(RSTACK_DEPTH)) u_rstack (
    .clk(clk), .rst_n(rst_n),
    .a_rd(a_rd_en & a_is_r), .a_peek(a_peek),
    .b_rd(b_rd_en & b_is_r), .b_peek(b_peek),
    .push(a_wr_en & a_is_r), .push_data(a_wr_data),
    .count(rstack_count), .a_val_c(r_a_val), .b_val_c(r_b_val),
    .udf_c(r_udf), .ovf_c(r_ovf)
  );

  // General registers; reads above sample the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (a_wr_en && !a_is_p && !a_is_r) begin
      regs[a_sel] <= a_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_data <= '0;
      b_rd_data <= '0;
      err_flags <= '0;
    end else begin
      if (a_rd_en) a_rd_data <= a_val_c;
      if (b_rd_en) b_rd_data <= b_val_c;
      // New errors win over a same-cycle clear.
      err_flags <= (err_clr ? 4'b0000 : err_flags) | {r_ovf, r_udf, p_ovf, p_udf};
    end
  end

  assign pstack_full  = (pstack_count == PCW'(PSTACK_DEPTH));
  assign pstack_empty = (pstack_count == '0);
  assign rstack_full  = (rstack_count == RCW'(RSTACK_DEPTH));
  assign rstack_empty = (rstack_count == '0);
endmodule

// File: tb/tb_stacked_register_file.sv
// Table-driven bench for stacked_register_file: vectors carry hand-derived expectations,
// queued on drive and compared after the clock edge, plus an async-reset sequence.

module tb_stacked_register_file;
  localparam logic [3:0] P = 4'd15;
  localparam logic [3:0] R = 4'd14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a_sel, b_sel;
  logic        a_rd_en, b_rd_en, a_peek, b_peek, a_wr_en, err_clr;
  logic [15:0] a_wr_data, a_rd_data, b_rd_data;
  logic [4:0]  pstack_count, rstack_count;
  logic        pstack_full, pstack_empty, rstack_full, rstack_empty;
  logic [3:0]  err_flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stacked_register_file dut (
    .clk(clk), .rst_n(rst_n),
    .a_sel(a_sel), .b_sel(b_sel),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
    .a_peek(a_peek), .b_peek(b_peek),
    .a_wr_en(a_wr_en), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .pstack_count(pstack_count), .rstack_count(rstack_count),
    .pstack_full(pstack_full), .pstack_empty(pstack_empty),
    .rstack_full(rstack_full), .rstack_empty(rstack_empty),
    .err_flags(err_flags), .err_clr(err_clr)
  );

  typedef struct {
    logic [15:0] a, b;
    logic [4:0]  pc, rc;
    logic [3:0]  err;
  } exp_t;

  typedef struct {
    logic [3:0]  a_sel, b_sel;
    logic        a_rd, b_rd, a_pk, b_pk, wr, clr;
    logic [15:0] wd;
    exp_t        exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic [3:0] as, input logic [3:0] bs,
                              input logic ar, input logic br, input logic apk, input logic bpk,
                              input logic wr, input logic clr, input logic [15:0] wd,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic [4:0] pc, input logic [4:0] rc, input logic [3:0] er);
    vec_t v;
    v.a_sel = as; v.b_sel = bs; v.a_rd = ar; v.b_rd = br;
    v.a_pk = apk; v.b_pk = bpk; v.wr = wr; v.clr = clr; v.wd = wd;
    v.exp.a = ea; v.exp.b = eb; v.exp.pc = pc; v.exp.rc = rc; v.exp.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    a_sel = '0; b_sel = '0; a_rd_en = 0; b_rd_en = 0; a_peek = 0; b_peek = 0;
    a_wr_en = 0; err_clr = 0; a_wr_data = '0;
  endtask

  task automatic run_vecs();
    exp_t e;
    foreach (vecs[i]) begin
      @(negedge clk);
      a_sel = vecs[i].a_sel; b_sel = vecs[i].b_sel;
      a_rd_en = vecs[i].a_rd; b_rd_en = vecs[i].b_rd;
      a_peek = vecs[i].a_pk; b_peek = vecs[i].b_pk;
      a_wr_en = vecs[i].wr; err_clr = vecs[i].clr; a_wr_data = vecs[i].wd;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", i, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("a_rd_data", i, 32'(a_rd_data), 32'(e.a));
        chk("b_rd_data", i, 32'(b_rd_data), 32'(e.b));
        chk("pstack_count", i, 32'(pstack_count), 32'(e.pc));
        chk("rstack_count", i, 32'(rstack_count), 32'(e.rc));
        chk("err_flags", i, 32'(err_flags), 32'(e.err));
        chk("pstack_full_empty", i, 32'({pstack_full, pstack_empty}),
            32'({e.pc == 5'd16, e.pc == 5'd0}));
        chk("rstack_full_empty", i, 32'({rstack_full, rstack_empty}),
            32'({e.rc == 5'd16, e.rc == 5'd0}));
      end
    end
    vecs.delete();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", -1, 32'(a_rd_data), 32'h0);
    chk("reset_b", -1, 32'(b_rd_data), 32'h0);
    chk("reset_counts", -1, 32'({pstack_count, rstack_count}), 32'h0);
    chk("reset_flags", -1, 32'({pstack_full, pstack_empty, rstack_full, rstack_empty, err_flags}), 32'b0101_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // General registers, stacks, underflow/overflow and error clearing.
    vecs.push_back(mk(4'd3, 4'd0, 0, 0, 0, 0, 1, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 4'b0000));
    vecs.push_back(mk(4'd3, 4'd3, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h1234, 0, 0, 4'b0000));
    vecs.push_back(mk(4'd3, 4'd0, 1, 0, 0, 0, 1, 0, 16'h5555, 16'h1234, 16'h1234, 0, 0, 4'b0000));
    vecs.push_back(mk(4'd3, 4'd0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h5555, 16'h1234, 0, 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 0, 0, 0, 0, 1, 0, 16'h000A, 16'h5555, 16'h1234, 1, 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 0, 0, 0, 0, 1, 0, 16'h000B, 16'h5555, 16'h1234, 2, 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 0, 0, 0, 0, 1, 0, 16'h000C, 16'h5555, 16'h1234, 3, 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h000C, 16'h1234, 3, 0, 4'b0000));
    vecs.push_back(mk(P, P, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h000C, 16'h000B, 1, 0, 4'b0000));
    vecs.push_back(mk(R, 4'd0, 0, 0, 0, 0, 1, 0, 16'h0011, 16'h000C, 16'h000B, 1, 1, 4'b0000));
    vecs.push_back(mk(R, 4'd0, 1, 0, 0, 0, 1, 0, 16'h0022, 16'h0011, 16'h000B, 1, 1, 4'b0000));
    vecs.push_back(mk(R, 4'd0, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0022, 16'h000B, 1, 1, 4'b0000));
    vecs.push_back(mk(R, 4'd0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0022, 16'h000B, 1, 0, 4'b0000));
    vecs.push_back(mk(4'd0, R, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0022, 16'h0000, 1, 0, 4'b0100));
    vecs.push_back(mk(4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0022, 16'h0000, 1, 0, 4'b0000));
    vecs.push_back(mk(4'd0, R, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0022, 16'h0000, 1, 0, 4'b0100));
    vecs.push_back(mk(4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0022, 16'h0000, 1, 0, 4'b0000));
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk(P, 4'd0, 0, 0, 0, 0, 1, 0, 16'(16'h0100 + i), 16'h0022, 16'h0000,
                        5'(2 + i), 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 0, 0, 0, 0, 1, 0, 16'hDEAD, 16'h0022, 16'h0000, 16, 0, 4'b0010));
    vecs.push_back(mk(4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0022, 16'h0000, 16, 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 1, 0, 0, 0, 1, 0, 16'hBEEF, 16'h010E, 16'h0000, 16, 0, 4'b0000));
    vecs.push_back(mk(P, 4'd0, 1, 0, 1, 0, 0, 0, 16'h0000, 16'hBEEF, 16'h0000, 16, 0, 4'b0000));
    vecs.push_back(mk(P, P, 1, 1, 0, 1, 0, 0, 16'h0000, 16'hBEEF, 16'h010D, 15, 0, 4'b0000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(R, 4'd0, 0, 0, 0, 0, 1, 0, 16'(16'h0030 + i), 16'hBEEF, 16'h010D,
                        15, 5'(1 + i), 4'b0000));
    run_vecs();

    // Asynchronous reset in the middle of a push burst.
    a_sel = R; a_wr_en = 1; a_wr_data = 16'h0099;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", -2, 32'(a_rd_data), 32'h0);
    chk("async_rst_b", -2, 32'(b_rd_data), 32'h0);
    chk("async_rst_pc", -2, 32'(pstack_count), 32'h0);
    chk("async_rst_rc", -2, 32'(rstack_count), 32'h0);
    chk("async_rst_empty", -2, 32'({pstack_empty, rstack_empty}), 32'b11);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: registers cleared, dropped push, dual-pop underflow saturation.
    vecs.push_back(mk(4'd3, 4'd0, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'b0000));
    vecs.push_back(mk(R, 4'd0, 0, 0, 0, 0, 1, 0, 16'h0077, 16'h0000, 16'h0000, 0, 1, 4'b0000));
    vecs.push_back(mk(R, R, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0077, 16'h0000, 0, 0, 4'b0100));
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stacked_register_file.md
Name: stacked_register_file

Overview:
Parametrised next-generation CPU register file: 2^SEL_BITS register selectors, two of which map to hardware LIFO stacks (parameter stack, return stack) instead of storage registers. Two read ports (A, B), one write port (shared with A's selector), registered 1-cycle reads. Adds configurable widths and depths, peek (non-destructive read), dual-pop on one stack, occupancy/full/empty status and sticky overflow/underflow error flags. Sits between decode and ALU in the CPU datapath.

Parameters:
WIDTH, 16, data width of registers and stack entries
SEL_BITS, 4, selector width; 2^SEL_BITS selector codes
PSTACK_SEL, 15, selector code mapped to the parameter stack
RSTACK_SEL, 14, selector code mapped to the return stack; must differ from PSTACK_SEL
PSTACK_DEPTH, 16, parameter stack entries (>=2)
RSTACK_DEPTH, 16, return stack entries (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_sel  in  SEL_BITS  port A selector (read and write)
b_sel  in  SEL_BITS  port B selector (read only)
a_rd_en  in  1  port A read strobe
b_rd_en  in  1  port B read strobe
a_peek  in  1  A stack read is non-destructive (ignored for general regs)
b_peek  in  1  B stack read is non-destructive
a_wr_en  in  1  write/push strobe at a_sel
a_wr_data  in  WIDTH  write/push data
a_rd_data  out  WIDTH  registered A read data
b_rd_data  out  WIDTH  registered B read data
pstack_count  out  clog2(PSTACK_DEPTH+1)  parameter stack occupancy
rstack_count  out  clog2(RSTACK_DEPTH+1)  return stack occupancy
pstack_full, pstack_empty  out  1 each  count==DEPTH / count==0
rstack_full, rstack_empty  out  1 each  same for return stack
err_flags  out  4  sticky {r_ovf, r_udf, p_ovf, p_udf}
err_clr  in  1  synchronous clear of err_flags

Behaviour:
- Reset (rst_n low, async): a_rd_data, b_rd_data, err_flags = 0; counts = 0 (empty=1, full=0); all general registers = 0. Stack storage is not reset. Reset mid-operation discards any in-flight pop/push.
- General register (sel not a stack code): write at clk edge when a_wr_en. Read: rd_data loads regs[sel] at clk edge when rd_en; otherwise rd_data holds. Read-before-write: same-cycle read of a written register returns the old value.
- Stack read with rd_en: rd_data loads the entry at clk edge, 1-cycle latency. Non-peek read pops (count decrements); peek leaves count unchanged.
- Port ordering per stack per cycle: A sees TOS. B sees NOS if A is popping the same stack, else TOS. pops = number of non-peek reads (0-2). Push applied after pops: new count = count - pops + push; pushed value becomes new TOS.
- Underflow: any read requiring an entry index >= count returns 0 for that port, sets the stack's udf flag; count saturates at 0 (only existing entries removed).
- Overflow: push when (count - pops) == DEPTH is dropped, sets ovf flag, count unchanged by the push.
- Simultaneous pop+push at full: pop frees the slot, push succeeds, no ovf.
- err_flags: set bits OR'd each cycle; err_clr clears at clk edge, but a same-cycle new error wins (bit stays 1).
- Status outputs are combinational from counts and reflect the post-edge state.

Test Plan:
- Reset, write r3=0x1234, read A and B r3 next cycle -> both rd_data=0x1234 one cycle after rd_en; write+read r3 same cycle with 0x5555 -> read returns 0x1234, next read 0x5555.
- Push 0x0A, 0x0B, 0x0C to PSTACK_SEL; A peek -> a_rd_data=0x0C, pstack_count=3; then A pop + B pop same stack -> a=0x0C, b=0x0B, count=1.
- Return stack holding 0x11: A pop + push 0x22 same cycle -> a_rd_data=0x11, rstack_count=1, next peek returns 0x22.
- Fill parameter stack to 16 (full=1), push again -> count stays 16, err_flags[1]=1; pop+push at full -> no new error, count=16.
- Empty return stack, B pop -> b_rd_data=0, err_flags[2]=1, count=0; err_clr -> flags 0; err_clr with concurrent underflow -> flag stays 1.
- Assert rst_n low mid push burst (count=5) -> outputs and counts 0 immediately, without waiting for a clk edge.
